// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, resolved-branch update and perf-counter signals
// master: pipeline side (drives pcaddr and upd_*; reads psel, pPC, counters)
// slave:  predictor side (reads pcaddr and upd_*; drives psel, pPC, counters)
interface branch_predictor_if;
    logic        [31:0] pcaddr;
    logic               psel;
    logic        [31:0] pPC;
    logic               upd_en;
    logic        [31:0] upd_pc;
    logic               upd_taken;
    logic        [31:0] upd_target;
    logic               upd_pred;
    logic        [31:0] br_cnt;
    logic        [31:0] misp_cnt;
    modport master (
        output pcaddr, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
        input  psel, pPC, br_cnt, misp_cnt
    );
    modport slave (
        input  pcaddr, upd_en, upd_pc, upd_taken, upd_target, upd_pred,
        output psel, pPC, br_cnt, misp_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters and perf counters
// CLK, nRST (async, active-low); bus.slave: pcaddr -> psel/pPC lookup,
// upd_* resolved-branch update, br_cnt/misp_cnt saturating counters
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic CLK,
    input  logic nRST,
    branch_predictor_if.slave bus
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 32 - IDX - 2;

    logic          valid_q [ENTRIES];
    logic          valid_d [ENTRIES];
    logic [TW-1:0] tag_q   [ENTRIES];
    logic [TW-1:0] tag_d   [ENTRIES];
    logic [31:0]   target_q[ENTRIES];
    logic [31:0]   target_d[ENTRIES];
    logic [1:0]    ctr_q   [ENTRIES];
    logic [1:0]    ctr_d   [ENTRIES];
    logic [31:0]   br_cnt_q, br_cnt_d, misp_cnt_q, misp_cnt_d;

    logic [IDX-1:0] lk_idx, up_idx;
    logic [TW-1:0]  lk_tag, up_tag;
    logic           lk_hit, up_hit;
    logic [1:0]     up_ctr;

    assign lk_idx = bus.pcaddr[IDX+1:2];
    assign lk_tag = bus.pcaddr[31:IDX+2];
    assign up_idx = bus.upd_pc[IDX+1:2];
    assign up_tag = bus.upd_pc[31:IDX+2];

    // lookup reads registered state only, so a same-cycle update is not bypassed
    assign lk_hit = valid_q[lk_idx] && tag_q[lk_idx] == lk_tag;
    assign up_hit = valid_q[up_idx] && tag_q[up_idx] == up_tag;
    assign up_ctr = ctr_q[up_idx];

    assign bus.psel     = lk_hit & ctr_q[lk_idx][1];
    assign bus.pPC      = bus.psel ? target_q[lk_idx] : bus.pcaddr + 32'd4;
    assign bus.br_cnt   = br_cnt_q;
    assign bus.misp_cnt = misp_cnt_q;

    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        target_d   = target_q;
        ctr_d      = ctr_q;
        br_cnt_d   = br_cnt_q;
        misp_cnt_d = misp_cnt_q;
        if (bus.upd_en) begin
            if (up_hit) begin
                ctr_d[up_idx] = bus.upd_taken ? (up_ctr == 2'b11 ? up_ctr : up_ctr + 2'd1)
                                              : (up_ctr == 2'b00 ? up_ctr : up_ctr - 2'd1);
                if (bus.upd_taken)
                    target_d[up_idx] = bus.upd_target;
            end else if (bus.upd_taken) begin
                // taken miss replaces whatever occupies the slot, starting weakly taken
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.upd_target;
                ctr_d[up_idx]    = 2'b10;
            end
            br_cnt_d   = br_cnt_q == '1 ? br_cnt_q : br_cnt_q + 32'd1;
            misp_cnt_d = (bus.upd_pred != bus.upd_taken && misp_cnt_q != '1) ? misp_cnt_q + 32'd1
                                                                              : misp_cnt_q;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            br_cnt_q   <= '0;
            misp_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            br_cnt_q   <= br_cnt_d;
            misp_cnt_q <= misp_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor
module tb_branch_predictor;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    branch_predictor_if bp ();

    branch_predictor #(.ENTRIES(16)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bp)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one-cycle update pulse, inputs changed 1ns after an edge, result sampled 1ns after the next
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input logic pred);
        bp.upd_en     = 1'b1;
        bp.upd_pc     = pc;
        bp.upd_taken  = taken;
        bp.upd_target = tgt;
        bp.upd_pred   = pred;
        @(posedge CLK);
        #1;
        bp.upd_en = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic ps, input logic [31:0] ppc);
        bp.pcaddr = pc;
        #1;
        check({tag, "_psel"}, {31'd0, bp.psel}, {31'd0, ps});
        check({tag, "_pPC"}, bp.pPC, ppc);
    endtask

    initial begin
        bp.pcaddr     = 32'h40;
        bp.upd_en     = 1'b0;
        bp.upd_pc     = 32'h0;
        bp.upd_taken  = 1'b0;
        bp.upd_target = 32'h0;
        bp.upd_pred   = 1'b0;
        #23;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        look("rst", 32'h40, 1'b0, 32'h44);
        check("rst_br", bp.br_cnt, 32'd0);
        check("rst_misp", bp.misp_cnt, 32'd0);
        look("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("alloc", 32'h40, 1'b1, 32'h100);
        check("alloc_br", bp.br_cnt, 32'd1);
        check("alloc_misp", bp.misp_cnt, 32'd1);

        upd(32'h80, 1'b0, 32'h999, 1'b0);
        check("nt_miss_br", bp.br_cnt, 32'd2);
        check("nt_miss_misp", bp.misp_cnt, 32'd1);
        look("nt_miss80", 32'h80, 1'b0, 32'h84);
        look("nt_miss40", 32'h40, 1'b1, 32'h100);

        upd(32'h40, 1'b0, 32'h0, 1'b1);
        look("hyst_nt", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("hyst_t", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        upd(32'h40, 1'b1, 32'h100, 1'b1);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        look("sat_nt", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 1'b1, 32'h180, 1'b1);
        look("retarget", 32'h40, 1'b1, 32'h180);
        check("hyst_br", bp.br_cnt, 32'd9);
        check("hyst_misp", bp.misp_cnt, 32'd4);

        look("alias_miss", 32'h440, 1'b0, 32'h444);
        upd(32'h440, 1'b1, 32'h200, 1'b0);
        look("alias_new", 32'h440, 1'b1, 32'h200);
        look("alias_old", 32'h40, 1'b0, 32'h44);

        bp.upd_en     = 1'b1;
        bp.upd_pc     = 32'h80;
        bp.upd_taken  = 1'b1;
        bp.upd_target = 32'h300;
        bp.upd_pred   = 1'b0;
        look("same_pre", 32'h80, 1'b0, 32'h84);
        @(posedge CLK);
        #1;
        bp.upd_en = 1'b0;
        look("same_post", 32'h80, 1'b1, 32'h300);
        check("same_br", bp.br_cnt, 32'd11);
        check("same_misp", bp.misp_cnt, 32'd6);

        nRST = 1'b0;
        look("arst", 32'h80, 1'b0, 32'h84);
        check("arst_br", bp.br_cnt, 32'd0);
        check("arst_misp", bp.misp_cnt, 32'd0);
        #1;
        nRST = 1'b1;
        look("arst_40", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b1, 32'h500, 1'b1);
        look("post_rst", 32'h40, 1'b1, 32'h500);
        check("post_rst_br", bp.br_cnt, 32'd1);
        check("post_rst_misp", bp.misp_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
